// File: rtl/memshare_coladdr_skid_buf.sv
// rtl/memshare_coladdr_skid_buf.sv - single-entry column-address/shift skid buffer with allocation sequence tagging
//
// Purpose: forwards each column-address/shift request, or defers it by one slot
// through a one-entry skid register under control of isColAddr_skid_i. Request
// order is preserved. Each issued request carries its allocation sequence index
// within the current pipeline cycle.
//
// Ports:
//   sys_clk            system clock, rising edge
//   rstn               synchronous active-low reset
//   rqst_valid_i       incoming request valid
//   colAddr_i          incoming column address
//   shift_i            incoming shift factor
//   isColAddr_skid_i   1 = defer through skid, 0 = forward
//   pipeCycle_begin_i  first cycle of a pipeline cycle (restarts tagging)
//   out_valid_o        issued request valid (registered)
//   colAddr_o          issued column address (holds when nothing issues)
//   shift_o            issued shift factor (holds when nothing issues)
//   allocSeq_o         allocation sequence tag of the issued request
//   skid_full_o        skid entry occupied
//   seq_ovf_o          sticky: more issues than tags in one pipeline cycle

module memshare_coladdr_skid_buf #(
  parameter int COL_ADDR_W        = 4,
  parameter int SHIFT_W           = 4,
  parameter int MAX_ALLOC_SEQ_NUM = 3,
  parameter int SEQ_W             = $clog2(MAX_ALLOC_SEQ_NUM + 1)
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  rqst_valid_i,
  input  logic [COL_ADDR_W-1:0] colAddr_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic                  isColAddr_skid_i,
  input  logic                  pipeCycle_begin_i,
  output logic                  out_valid_o,
  output logic [COL_ADDR_W-1:0] colAddr_o,
  output logic [SHIFT_W-1:0]    shift_o,
  output logic [SEQ_W-1:0]      allocSeq_o,
  output logic                  skid_full_o,
  output logic                  seq_ovf_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  localparam logic [SEQ_W-1:0] MAX_SEQ = SEQ_W'(MAX_ALLOC_SEQ_NUM);

  state_e                  state_q;
  logic [COL_ADDR_W-1:0]   skid_col_q;
  logic [SHIFT_W-1:0]      skid_sh_q;
  logic [SEQ_W-1:0]        seq_cnt_q;
  // Set once the tag MAX has been handed out in this pipeline cycle; a second
  // issue at MAX is the overflow case (seq_cnt alone cannot tell "MAX is next"
  // from "MAX already used").
  logic                    max_used_q;

  logic                    out_valid_q;
  logic [COL_ADDR_W-1:0]   col_q;
  logic [SHIFT_W-1:0]      sh_q;
  logic [SEQ_W-1:0]        tag_q;
  logic                    full_q;
  logic                    ovf_q;

  logic                    issue_d;
  logic [COL_ADDR_W-1:0]   col_d;
  logic [SHIFT_W-1:0]      sh_d;
  logic [SEQ_W-1:0]        cur_d;
  logic                    max_used_eff_d;

  always_comb begin
    // A held entry always issues first, whatever the inputs do.
    issue_d        = (state_q == HELD) | (rqst_valid_i & ~isColAddr_skid_i);
    col_d          = colAddr_i;
    sh_d           = shift_i;
    if (state_q == HELD) begin
      col_d = skid_col_q;
      sh_d  = skid_sh_q;
    end
    cur_d          = pipeCycle_begin_i ? '0 : seq_cnt_q;
    max_used_eff_d = max_used_q & ~pipeCycle_begin_i;
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      skid_col_q  <= '0;
      skid_sh_q   <= '0;
      seq_cnt_q   <= '0;
      max_used_q  <= 1'b0;
      out_valid_q <= 1'b0;
      col_q       <= '0;
      sh_q        <= '0;
      tag_q       <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= issue_d;

      if (issue_d) begin
        col_q     <= col_d;
        sh_q      <= sh_d;
        tag_q     <= cur_d;
        seq_cnt_q <= (cur_d == MAX_SEQ) ? MAX_SEQ : cur_d + 1'b1;
        if (cur_d == MAX_SEQ) begin
          max_used_q <= 1'b1;
          if (max_used_eff_d) ovf_q <= 1'b1;
        end else begin
          max_used_q <= max_used_eff_d;
        end
      end else begin
        seq_cnt_q  <= cur_d;
        max_used_q <= max_used_eff_d;
      end

      case (state_q)
        EMPTY: begin
          if (rqst_valid_i && isColAddr_skid_i) begin
            skid_col_q <= colAddr_i;
            skid_sh_q  <= shift_i;
            state_q    <= HELD;
            full_q     <= 1'b1;
          end
        end
        HELD: begin
          // The held entry issues this cycle; a new request (any sel) takes its place.
          if (rqst_valid_i) begin
            skid_col_q <= colAddr_i;
            skid_sh_q  <= shift_i;
          end else begin
            state_q <= EMPTY;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= EMPTY;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign colAddr_o   = col_q;
  assign shift_o     = sh_q;
  assign allocSeq_o  = tag_q;
  assign skid_full_o = full_q;
  assign seq_ovf_o   = ovf_q;

endmodule
